puck_physics: RTL and testbench

//  Air-hockey puck engine that runs upstream of the VGA renderer. It supplies puck_x/puck_y
//  in renderer coordinates: the hc/vc counter space, porches included.

---
 rtl/puck_physics.sv | 236 +++++++++++++++++++++++
 tb/tb_puck_physics.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/puck_physics.sv
// Air-hockey puck engine: once per frame tick moves the puck, resolves paddle and wall
// contacts, scores goals and sequences serve / game over, in renderer hc/vc coordinates.
//   state  | meaning
//   IDLE   | waiting for a physics tick
//   STEP   | n = p + v
//   PADDLE | paddle contact test, velocity redirect
//   WALL   | wall clamp / bounce, goal detection
//   COMMIT | p <= n
//   GOAL   | goal pulse, score, recentre
//   SERVE  | puck held at centre for SERVE_TICKS ticks
//   OVER   | frozen until clr
module puck_physics #(
  parameter int TICK_DIV    = 1666667,
  parameter int X_MIN       = 194,
  parameter int X_MAX       = 736,
  parameter int Y_MIN       = 71,
  parameter int Y_MAX       = 472,
  parameter int CENTER_X    = 465,
  parameter int CENTER_Y    = 271,
  parameter int GOAL_Y_LO   = 221,
  parameter int GOAL_Y_HI   = 321,
  parameter int PUCK_R      = 10,
  parameter int HIT_R2      = 625,
  parameter int INIT_VX     = 7,
  parameter int INIT_VY     = 3,
  parameter int SERVE_TICKS = 30,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] dot_x_1,
  input  logic [9:0] dot_y_1,
  input  logic [9:0] dot_x_2,
  input  logic [9:0] dot_y_2,
  output logic [9:0] puck_x,
  output logic [9:0] puck_y,
  output logic       goal_1,
  output logic       goal_2,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic       game_over
);
  typedef enum logic [2:0] {IDLE, STEP, PADDLE, WALL, COMMIT, GOAL, SERVE, OVER} state_t;

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW  = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam int AVX = (INIT_VX < 0) ? -INIT_VX : INIT_VX;
  localparam logic signed [4:0]  VXP  = 5'(AVX);
  localparam logic signed [4:0]  VXN  = -VXP;
  localparam logic signed [4:0]  VX0  = 5'(INIT_VX);
  localparam logic signed [4:0]  VY0  = 5'(INIT_VY);
  localparam logic signed [10:0] X_LO = 11'(X_MIN + PUCK_R);
  localparam logic signed [10:0] X_HI = 11'(X_MAX - PUCK_R);
  localparam logic signed [10:0] Y_LO = 11'(Y_MIN + PUCK_R);
  localparam logic signed [10:0] Y_HI = 11'(Y_MAX - PUCK_R);

  state_t             state_q, state_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [SW-1:0]      scnt_q, scnt_d;
  logic [9:0]         px_q, px_d, py_q, py_d;
  logic signed [10:0] nx_q, nx_d, ny_q, ny_d;
  logic signed [4:0]  vx_q, vx_d, vy_q, vy_d;
  logic [3:0]         score1_q, score1_d, score2_q, score2_d, sc;
  logic               goal1_q, goal1_d, goal2_q, goal2_d, over_q, over_d;
  logic               p2_scored_q, p2_scored_d;
  logic               tick, hit1, hit2, in_mouth;
  logic [20:0]        d2_1, d2_2;
  logic [9:0]         hx, hy;

  function automatic logic [20:0] sq_dist(input logic signed [10:0] nx, input logic signed [10:0] ny,
                                          input logic [9:0] ax, input logic [9:0] ay);
    logic signed [11:0] ex, ey;
    ex = {nx[10], nx} - $signed({2'b00, ax});
    ey = {ny[10], ny} - $signed({2'b00, ay});
    return 21'(24'(ex) * 24'(ex)) + 21'(24'(ey) * 24'(ey));
  endfunction

  function automatic logic signed [4:0] mag(input logic signed [4:0] v);
    return v[4] ? -v : v;
  endfunction

  // Down-counter reloads at terminal count; first tick lands TICK_DIV clk after reset.
  assign tick     = (tcnt_q == '0);
  assign tcnt_d   = tick ? TW'(TICK_DIV - 1) : tcnt_q - 1'b1;
  assign d2_1     = sq_dist(nx_q, ny_q, dot_x_1, dot_y_1);
  assign d2_2     = sq_dist(nx_q, ny_q, dot_x_2, dot_y_2);
  assign hit1     = (d2_1 < 21'(HIT_R2));
  assign hit2     = !hit1 && (d2_2 < 21'(HIT_R2));
  assign hx       = hit1 ? dot_x_1 : dot_x_2;
  assign hy       = hit1 ? dot_y_1 : dot_y_2;
  assign in_mouth = (py_q >= 10'(GOAL_Y_LO)) && (py_q <= 10'(GOAL_Y_HI));

  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    px_d        = px_q;
    py_d        = py_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    goal1_d     = 1'b0;
    goal2_d     = 1'b0;
    over_d      = over_q;
    p2_scored_d = p2_scored_q;
    sc          = '0;
    case (state_q)
      IDLE: if (tick) state_d = STEP;
      STEP: begin
        nx_d    = $signed({1'b0, px_q}) + 11'(vx_q);
        ny_d    = $signed({1'b0, py_q}) + 11'(vy_q);
        state_d = PADDLE;
      end
      PADDLE: begin
        if (hit1 || hit2) begin
          nx_d = $signed({1'b0, px_q});
          ny_d = $signed({1'b0, py_q});
          if (px_q > hx) vx_d = mag(vx_q);
          else if (px_q < hx) vx_d = -mag(vx_q);
          if (py_q > hy) vy_d = mag(vy_q);
          else if (py_q < hy) vy_d = -mag(vy_q);
        end
        state_d = WALL;
      end
      WALL: begin
        if (ny_q < Y_LO) begin
          ny_d = Y_LO;
          vy_d = -vy_q;
        end else if (ny_q > Y_HI) begin
          ny_d = Y_HI;
          vy_d = -vy_q;
        end
        state_d = COMMIT;
        if (nx_q < X_LO) begin
          if (in_mouth) begin
            p2_scored_d = 1'b1;
            state_d     = GOAL;
          end else begin
            nx_d = X_LO;
            vx_d = -vx_q;
          end
        end else if (nx_q > X_HI) begin
          if (in_mouth) begin
            p2_scored_d = 1'b0;
            state_d     = GOAL;
          end else begin
            nx_d = X_HI;
            vx_d = -vx_q;
          end
        end
      end
      COMMIT: begin
        px_d    = nx_q[9:0];
        py_d    = ny_q[9:0];
        state_d = IDLE;
      end
      GOAL: begin
        px_d = 10'(CENTER_X);
        py_d = 10'(CENTER_Y);
        vy_d = VY0;
        if (p2_scored_q) begin
          sc       = score2_q + {3'b000, (score2_q != 4'hF)};
          score2_d = sc;
          goal2_d  = 1'b1;
          vx_d     = VXN;
        end else begin
          sc       = score1_q + {3'b000, (score1_q != 4'hF)};
          score1_d = sc;
          goal1_d  = 1'b1;
          vx_d     = VXP;
        end
        if (sc >= 4'(WIN_SCORE)) begin
          over_d  = 1'b1;
          state_d = OVER;
        end else begin
          scnt_d  = SW'(SERVE_TICKS - 1);
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (tick) begin
          if (scnt_q == '0) state_d = IDLE;
          else scnt_d = scnt_q - 1'b1;
        end
      end
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      tcnt_q      <= TW'(TICK_DIV - 1);
      scnt_q      <= '0;
      px_q        <= 10'(CENTER_X);
      py_q        <= 10'(CENTER_Y);
      nx_q        <= '0;
      ny_q        <= '0;
      vx_q        <= VX0;
      vy_q        <= VY0;
      score1_q    <= '0;
      score2_q    <= '0;
      goal1_q     <= 1'b0;
      goal2_q     <= 1'b0;
      over_q      <= 1'b0;
      p2_scored_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      scnt_q      <= scnt_d;
      px_q        <= px_d;
      py_q        <= py_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      goal1_q     <= goal1_d;
      goal2_q     <= goal2_d;
      over_q      <= over_d;
      p2_scored_q <= p2_scored_d;
    end
  end

  assign puck_x    = px_q;
  assign puck_y    = py_q;
  assign goal_1    = goal1_q;
  assign goal_2    = goal2_q;
  assign score_1   = score1_q;
  assign score_2   = score2_q;
  assign game_over = over_q;
endmodule

// File: tb/tb_puck_physics.sv
// Bench for puck_physics: five parameter variants run directed scenarios side by side,
// then variant 0 is driven with random paddles against a rule-level puck model.
module tb_puck_physics;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [9:0] dx1 [5];
  logic [9:0] dy1 [5];
  logic [9:0] dx2 [5];
  logic [9:0] dy2 [5];
  logic [9:0] px  [5];
  logic [9:0] py  [5];
  logic [3:0] s1  [5];
  logic [3:0] s2  [5];
  logic       g1  [5];
  logic       g2  [5];
  logic       go  [5];
  int total = 0;
  int bad   = 0;

  // variant: 0 default, 1 top wall, 2 paddle, 3 goal, 4 goal with WIN_SCORE=1
  localparam int CX [5] = '{465, 465, 465, 205, 205};
  localparam int CY [5] = '{271, 84, 271, 271, 271};
  localparam int VX [5] = '{7, 7, 7, -7, -7};
  localparam int VY [5] = '{3, -5, 0, 0, 0};
  localparam int WS [5] = '{7, 7, 7, 7, 1};

  always #5 clk = ~clk;

  for (genvar i = 0; i < 5; i++) begin : g_dut
    puck_physics #(.TICK_DIV(4), .CENTER_X(CX[i]), .CENTER_Y(CY[i]),
                   .INIT_VX(VX[i]), .INIT_VY(VY[i]), .WIN_SCORE(WS[i])) u_dut (
      .clk(clk), .clr(clr),
      .dot_x_1(dx1[i]), .dot_y_1(dy1[i]), .dot_x_2(dx2[i]), .dot_y_2(dy2[i]),
      .puck_x(px[i]), .puck_y(py[i]), .goal_1(g1[i]), .goal_2(g2[i]),
      .score_1(s1[i]), .score_2(s2[i]), .game_over(go[i]));
  end

  // reference model state (variant 0)
  int m_px, m_py, m_vx, m_vy, m_s1, m_s2, m_skip;
  bit m_over, m_g1, m_g2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic tickwait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One physics update as stated by the game rules; positions updated every 8 clk in
  // play (TICK_DIV=4, every second tick falls while the update is still in progress),
  // and a goal freezes the puck for 15 further update slots (30 serve ticks).
  task automatic model_slot(input int ax1, input int ay1, input int ax2, input int ay2);
    int nx, ny, d1, d2, hx, hy, avx, avy;
    bit hit, mouth;
    m_g1 = 0;
    m_g2 = 0;
    if (m_over) begin
    end else if (m_skip > 0) begin
      m_skip--;
    end else begin
      nx = m_px + m_vx;
      ny = m_py + m_vy;
      d1 = (nx - ax1) * (nx - ax1) + (ny - ay1) * (ny - ay1);
      d2 = (nx - ax2) * (nx - ax2) + (ny - ay2) * (ny - ay2);
      hit = (d1 < 625) || (d2 < 625);
      hx = (d1 < 625) ? ax1 : ax2;
      hy = (d1 < 625) ? ay1 : ay2;
      if (hit) begin
        nx = m_px; ny = m_py;
        avx = (m_vx < 0) ? -m_vx : m_vx;
        avy = (m_vy < 0) ? -m_vy : m_vy;
        if (m_px > hx) m_vx = avx; else if (m_px < hx) m_vx = -avx;
        if (m_py > hy) m_vy = avy; else if (m_py < hy) m_vy = -avy;
      end
      if (ny - 10 < 71) begin ny = 81; m_vy = -m_vy; end
      else if (ny + 10 > 472) begin ny = 462; m_vy = -m_vy; end
      mouth = (m_py >= 221) && (m_py <= 321);
      if (nx - 10 < 194) begin
        if (mouth) m_g2 = 1; else begin nx = 204; m_vx = -m_vx; end
      end else if (nx + 10 > 736) begin
        if (mouth) m_g1 = 1; else begin nx = 726; m_vx = -m_vx; end
      end
      if (m_g1 || m_g2) begin
        if (m_g1) m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
        else m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
        m_px = 465; m_py = 271; m_vx = m_g1 ? 7 : -7; m_vy = 3;
        if (m_s1 >= 7 || m_s2 >= 7) m_over = 1; else m_skip = 15;
      end else begin
        m_px = nx; m_py = ny;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      dx1[i] = '0; dy1[i] = '0; dx2[i] = '0; dy2[i] = '0;
    end
    dx1[2] = 10'd480; dy1[2] = 10'd271;

    do_reset();
    chk("rst_x", px[0], 465);      chk("rst_y", py[0], 271);
    chk("rst_s1", s1[0], 0);       chk("rst_s2", s2[0], 0);
    chk("rst_over", go[0], 0);     chk("rst_g1", g1[0], 0);
    chk("rst_g2", g2[0], 0);

    tickwait(7);
    chk("latency_hold_x", px[0], 465);
    tickwait(1);
    chk("move1_x", px[0], 472);    chk("move1_y", py[0], 274);
    chk("topwall1_x", px[1], 472); chk("topwall1_y", py[1], 81);
    chk("hit1_x", px[2], 465);     chk("hit1_y", py[2], 271);
    chk("goal_g2", g2[3], 1);      chk("goal_s2", s2[3], 1);
    chk("goal_s1", s1[3], 0);      chk("goal_x", px[3], 205);
    chk("goal_y", py[3], 271);
    chk("over_g2", g2[4], 1);      chk("over_flag", go[4], 1);
    chk("over_s2", s2[4], 1);
    dx1[2] = '0; dy1[2] = '0;
    tickwait(1);
    chk("goal_pulse_width", g2[3], 0);
    chk("over_pulse_width", g2[4], 0);
    tickwait(7);
    chk("move2_x", px[0], 479);    chk("move2_y", py[0], 277);
    chk("topwall2_x", px[1], 479); chk("topwall2_y", py[1], 86);
    chk("hit2_x", px[2], 458);     chk("hit2_y", py[2], 271);
    chk("serve_hold2_x", px[3], 205);
    tickwait(112);
    chk("serve_end_x", px[3], 205); chk("serve_end_s2", s2[3], 1);
    chk("serve_end_g2", g2[3], 0);
    tickwait(8);
    chk("regoal_g2", g2[3], 1);    chk("regoal_s2", s2[3], 2);
    chk("regoal_x", px[3], 205);
    tickwait(1);
    chk("regoal_pulse_width", g2[3], 0);
    tickwait(39);
    chk("frozen_x", px[4], 205);   chk("frozen_y", py[4], 271);
    chk("frozen_s2", s2[4], 1);    chk("frozen_over", go[4], 1);
    chk("frozen_g2", g2[4], 0);

    do_reset();
    chk("clr_over", go[4], 0);     chk("clr_s2e", s2[4], 0);
    chk("clr_xe", px[4], 205);     chk("clr_g2e", g2[4], 0);
    chk("clr_s2d", s2[3], 0);      chk("clr_x", px[0], 465);

    m_px = 465; m_py = 271; m_vx = 7; m_vy = 3;
    m_s1 = 0; m_s2 = 0; m_skip = 0; m_over = 0;
    for (int k = 0; k < 300; k++) begin
      int ax1, ay1, ax2, ay2;
      if ($urandom_range(0, 1) == 1) begin
        ax1 = m_px + int'($urandom_range(0, 40)) - 20;
        ay1 = m_py + int'($urandom_range(0, 40)) - 20;
      end else begin
        ax1 = int'($urandom_range(194, 736));
        ay1 = int'($urandom_range(71, 472));
      end
      if ($urandom_range(0, 3) == 0) begin
        ax2 = m_px + int'($urandom_range(0, 40)) - 20;
        ay2 = m_py + int'($urandom_range(0, 40)) - 20;
      end else begin
        ax2 = int'($urandom_range(194, 736));
        ay2 = int'($urandom_range(71, 472));
      end
      dx1[0] = 10'(ax1); dy1[0] = 10'(ay1);
      dx2[0] = 10'(ax2); dy2[0] = 10'(ay2);
      model_slot(ax1, ay1, ax2, ay2);
      tickwait(8);
      chk($sformatf("rnd%0d_x", k), px[0], m_px);
      chk($sformatf("rnd%0d_y", k), py[0], m_py);
      chk($sformatf("rnd%0d_s1", k), s1[0], m_s1);
      chk($sformatf("rnd%0d_s2", k), s2[0], m_s2);
      chk($sformatf("rnd%0d_g1", k), g1[0], m_g1);
      chk($sformatf("rnd%0d_g2", k), g2[0], m_g2);
      chk($sformatf("rnd%0d_over", k), go[0], m_over);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
